// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan path.
// Segment codes are active-low, bit0 = a ... bit6 = g.
package seg_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned SEL_W   = 6;
    localparam int unsigned FRAME_W = 1 + SEG_W + SEL_W;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StDwell
    } scan_state_e;

    typedef struct packed {
        logic [NIB_W*SEL_W-1:0] data;
        logic [SEL_W-1:0]       dp;
        logic [SEL_W-1:0]       blank;
        logic                   lzb;
    } disp_cfg_t;

    // Digits 5..1 that are zero with only zeros above them; digit 0 always shows.
    function automatic logic [SEL_W-1:0] lzb_mask(input logic [NIB_W*SEL_W-1:0] data);
        logic zeros;
        lzb_mask = '0;
        zeros    = 1'b1;
        for (int k = int'(SEL_W) - 1; k >= 1; k--) begin
            zeros       = zeros & (data[NIB_W*k +: NIB_W] == '0);
            lzb_mask[k] = zeros;
        end
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment code, purely combinational.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/seg_scan_scheduler.sv
// Multiplexed scan of a six-digit 595-driven display: double-buffered digit data,
// per-digit frame build and a valid/ready hand-off to the serial driver.
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned SCAN_HZ = 1000,
    parameter int unsigned NDIG    = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_upd,
    input  logic [4*NDIG-1:0]    i_disp_data,
    input  logic [NDIG-1:0]      i_dp_mask,
    input  logic [NDIG-1:0]      i_blank_mask,
    input  logic                 i_lzb_en,
    output logic [FRAME_W-1:0]   o_frame_data,
    output logic                 o_frame_valid,
    input  logic                 i_frame_ready,
    output logic [2:0]           o_scan_digit
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = $clog2(DIV);

    scan_state_e        r_state;
    scan_state_e        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_tick_pend;
    logic               w_tick_pend_nxt;
    logic [2:0]         r_digit;
    logic [2:0]         w_digit_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame_nxt;
    disp_cfg_t          r_pend;
    disp_cfg_t          r_act;
    disp_cfg_t          w_upd_cfg;
    disp_cfg_t          w_src;
    logic               w_tick;
    logic               w_load_act;
    logic [3:0]         w_nibble;
    logic [6:0]         w_hex;
    logic               w_dark;
    logic [SEG_W-1:0]   w_seg;
    logic [SEL_W-1:0]   w_sel;
    logic [SEL_W-1:0]   w_lzb;

    assign w_upd_cfg = {i_disp_data, i_dp_mask, i_blank_mask, i_lzb_en};
    assign w_tick    = (r_cnt == CNT_W'(DIV - 1));

    // Digit 0's LOAD is the cycle pending becomes active, so it reads pending directly.
    assign w_src    = (r_digit == 3'd0) ? r_pend : r_act;
    assign w_nibble = w_src.data[r_digit*NIB_W +: NIB_W];
    assign w_lzb    = w_src.lzb ? lzb_mask(w_src.data) : '0;
    assign w_dark   = w_src.blank[r_digit] | w_lzb[r_digit];
    assign w_seg    = {~w_src.dp[r_digit], (w_dark ? SEG_OFF : w_hex)};
    assign w_sel    = ~(SEL_W'(1) << r_digit);

    seg_hex_decode u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_hex)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_digit_nxt     = r_digit;
        w_frame_nxt     = r_frame;
        w_tick_pend_nxt = r_tick_pend;
        w_load_act      = 1'b0;
        if (w_tick && (r_state != StDwell)) begin
            w_tick_pend_nxt = 1'b1;
        end
        case (r_state)
            StIdle: w_state_nxt = StLoad;
            StLoad: begin
                w_frame_nxt = {1'b1, w_seg, w_sel};
                w_load_act  = (r_digit == 3'd0);
                w_state_nxt = StSend;
            end
            StSend: begin
                if (i_frame_ready) begin
                    w_state_nxt = StDwell;
                end
            end
            StDwell: begin
                if (w_tick || r_tick_pend) begin
                    w_tick_pend_nxt = 1'b0;
                    w_digit_nxt     = (r_digit == 3'(NDIG - 1)) ? 3'd0 : r_digit + 3'd1;
                    w_state_nxt     = StLoad;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_tick_pend <= 1'b0;
            r_digit     <= 3'd0;
            r_frame     <= '1;
            r_pend      <= '0;
            r_act       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_tick ? '0 : r_cnt + 1'b1;
            r_tick_pend <= w_tick_pend_nxt;
            r_digit     <= w_digit_nxt;
            r_frame     <= w_frame_nxt;
            if (i_upd) begin
                r_pend <= w_upd_cfg;
            end
            if (w_load_act) begin
                r_act <= r_pend;
            end
        end
    end

    assign o_frame_data  = r_frame;
    assign o_frame_valid = (r_state == StSend);
    assign o_scan_digit  = r_digit;

endmodule
